if_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decode stage's instr input.

---
 rtl/if_fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage. Holds the PC, issues requests to a variable-latency
// instruction memory (req/gnt handshake, in-order rvalid responses), buffers
// returned instructions in a QDEPTH-entry prefetch queue and presents the queue
// head plus its next-PC to decode every cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_IM_ID         decode not accepting; queue head is held
//   flow_change_ID_EX   redirect to dst_ID_EX, flush queue, drop in-flight data
//   dst_ID_EX           redirect target PC
//   hlt_ID_EX           stop issuing (sticky until reset)
//   im_req / im_addr    fetch request and address (= pc)
//   im_gnt              memory accepted the request this cycle
//   im_rvalid/im_rdata  response, returned in request order
//   instr / instr_vld   queue head (or the all-zero bubble when empty)
//   nxt_pc              address+1 of instr; holds last value while empty
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 17,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_IM_ID,
    input  logic               flow_change_ID_EX,
    input  logic [PC_W-1:0]    dst_ID_EX,
    input  logic               hlt_ID_EX,
    output logic               im_req,
    output logic [PC_W-1:0]    im_addr,
    input  logic               im_gnt,
    input  logic               im_rvalid,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_vld,
    output logic [PC_W-1:0]    nxt_pc
);

    localparam int              PTR_W      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int              CNT_W      = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W:0]   QDEPTH_OCC = (CNT_W + 1)'(QDEPTH);
    localparam logic [CNT_W-1:0] QDEPTH_CNT = CNT_W'(QDEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Architectural state
    logic [PC_W-1:0]    pc_reg;
    logic               halted_reg;
    logic [PC_W-1:0]    nxt_pc_hold_reg;

    // Prefetch queue: instruction plus its address+1
    logic [INSTR_W-1:0] q_instr_reg [QDEPTH];
    logic [PC_W-1:0]    q_pc_reg    [QDEPTH];
    logic [PTR_W-1:0]   q_rd_ptr_reg, q_wr_ptr_reg;
    logic [CNT_W-1:0]   q_cnt_reg;

    // In-flight tag FIFO. The live bit plays the role of the epoch tag: a
    // redirect clears every live bit at once, so a response is kept only if no
    // redirect happened since it was issued, however many redirects occur
    // while it is outstanding.
    logic [PC_W-1:0]    t_pc_reg [QDEPTH];
    logic [QDEPTH-1:0]  t_live_reg;
    logic [PTR_W-1:0]   t_rd_ptr_reg, t_wr_ptr_reg;
    logic [CNT_W-1:0]   if_cnt_reg;

    logic               q_empty;
    logic               head_pop;
    logic [CNT_W:0]     occ;
    logic               issue;
    logic               ret;
    logic               ret_live;
    logic               q_wr;
    logic               q_pop;
    logic [PC_W-1:0]    pc_inc;
    logic [QDEPTH-1:0]  q_we;
    logic [QDEPTH-1:0]  t_we;

    assign q_empty  = (q_cnt_reg == '0);
    assign head_pop = !stall_IM_ID && !q_empty;

    // The entry decode hands over this cycle is counted as already free, so a
    // zero-wait memory can sustain one instruction per cycle with two credits.
    assign occ      = {1'b0, q_cnt_reg} + {1'b0, if_cnt_reg} - {{CNT_W{1'b0}}, head_pop};

    assign im_req   = rst_n && !halted_reg && !flow_change_ID_EX && (occ < QDEPTH_OCC);
    assign im_addr  = pc_reg;
    assign issue    = im_req && im_gnt;
    assign pc_inc   = pc_reg + 1'b1;

    // A response with nothing outstanding is ignored.
    assign ret      = im_rvalid && (if_cnt_reg != '0);
    assign ret_live = ret && t_live_reg[t_rd_ptr_reg];

    // Redirect wins over both the queue write and the consume.
    assign q_wr     = ret_live && !flow_change_ID_EX;
    assign q_pop    = head_pop && !flow_change_ID_EX;

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_we
            assign q_we[gi] = q_wr  && (q_wr_ptr_reg == PTR_W'(gi));
            assign t_we[gi] = issue && (t_wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    assign instr     = q_empty ? '0 : q_instr_reg[q_rd_ptr_reg];
    assign instr_vld = !q_empty;
    assign nxt_pc    = q_empty ? nxt_pc_hold_reg : q_pc_reg[q_rd_ptr_reg];

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            halted_reg      <= 1'b0;
            nxt_pc_hold_reg <= '0;
            q_rd_ptr_reg    <= '0;
            q_wr_ptr_reg    <= '0;
            q_cnt_reg       <= '0;
            t_live_reg      <= '0;
            t_rd_ptr_reg    <= '0;
            t_wr_ptr_reg    <= '0;
            if_cnt_reg      <= '0;
        end else begin
            if (flow_change_ID_EX) begin
                pc_reg <= dst_ID_EX;
            end else if (issue) begin
                pc_reg <= pc_inc;
            end

            if (hlt_ID_EX) begin
                halted_reg <= 1'b1;
            end

            if (!q_empty) begin
                nxt_pc_hold_reg <= q_pc_reg[q_rd_ptr_reg];
            end

            // Stale requests keep their credit until the response returns.
            if_cnt_reg <= if_cnt_reg + CNT_W'(issue) - CNT_W'(ret);
            if (issue) begin
                t_wr_ptr_reg <= ptr_inc(t_wr_ptr_reg);
            end
            if (ret) begin
                t_rd_ptr_reg <= ptr_inc(t_rd_ptr_reg);
            end
            if (flow_change_ID_EX) begin
                t_live_reg <= '0;
            end else begin
                t_live_reg <= t_live_reg | t_we;
            end

            if (flow_change_ID_EX) begin
                q_cnt_reg    <= '0;
                q_rd_ptr_reg <= '0;
                q_wr_ptr_reg <= '0;
            end else begin
                q_cnt_reg <= q_cnt_reg + CNT_W'(q_wr) - CNT_W'(q_pop);
                if (q_wr) begin
                    q_wr_ptr_reg <= ptr_inc(q_wr_ptr_reg);
                end
                if (q_pop) begin
                    q_rd_ptr_reg <= ptr_inc(q_rd_ptr_reg);
                end
            end
        end
    end

    // Payload storage; only read while the matching count says it is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (q_we[i]) begin
                q_instr_reg[i] <= im_rdata;
                q_pc_reg[i]    <= t_pc_reg[t_rd_ptr_reg];
            end
            if (t_we[i]) begin
                t_pc_reg[i] <= pc_inc;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(im_rvalid && (if_cnt_reg == '0)))
                else $error("if_fetch_unit: im_rvalid with no request in flight");
            assert (!(q_wr && (q_cnt_reg == QDEPTH_CNT)))
                else $error("if_fetch_unit: prefetch queue write while full");
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_IM_ID;
    logic        flow_change_ID_EX;
    logic [15:0] dst_ID_EX;
    logic        hlt_ID_EX;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [16:0] im_rdata;
    logic [16:0] instr;
    logic        instr_vld;
    logic [15:0] nxt_pc;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .PC_W(16), .INSTR_W(17), .RESET_PC(16'h0000), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .stall_IM_ID(stall_IM_ID), .flow_change_ID_EX(flow_change_ID_EX),
        .dst_ID_EX(dst_ID_EX), .hlt_ID_EX(hlt_ID_EX),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .instr(instr), .instr_vld(instr_vld), .nxt_pc(nxt_pc)
    );

    // Reference model: requests granted but not answered (with a flag marking
    // those made stale by a later redirect), and addresses delivered to the
    // prefetch queue but not yet consumed by decode.
    typedef struct { logic [15:0] addr; bit stale; int due; } flight_t;
    flight_t     flight_q[$];
    logic [15:0] queue_m[$];
    logic [15:0] issue_addr_m;
    logic [15:0] last_nxt_m;
    bit          halted_m;

    int cyc, n_cmp, n_fail;
    int lat_lo, lat_hi, gnt_pct;

    typedef struct {
        bit          stall;
        bit          gnt;
        bit          exp_req;
        logic [15:0] exp_addr;
        bit          exp_vld;
        logic [16:0] exp_instr;
        logic [15:0] exp_nxt;
    } vec_t;
    vec_t vecs[8];

    // Instruction memory contents: odd multiplier keeps every address distinct.
    function automatic logic [16:0] im_word(input logic [15:0] a);
        logic [16:0] w;
        w = {1'b0, a} * 17'd179 + 17'd4660;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        flight_q.delete();
        queue_m.delete();
        issue_addr_m = 16'h0000;
        last_nxt_m   = 16'h0000;
        halted_m     = 1'b0;
    endtask

    // Drive one cycle's inputs (called #1 after a rising edge) and move to the
    // falling edge where outputs are sampled.
    task automatic cyc_begin(input bit st, input bit fl, input logic [15:0] d, input bit h);
        stall_IM_ID       = st;
        flow_change_ID_EX = fl;
        dst_ID_EX         = d;
        hlt_ID_EX         = h;
        im_gnt            = (int'($urandom_range(99)) < gnt_pct);
        if (flight_q.size() > 0 && flight_q[0].due <= cyc) begin
            im_rvalid = 1'b1;
            im_rdata  = im_word(flight_q[0].addr);
        end else begin
            im_rvalid = 1'b0;
            im_rdata  = 17'($urandom);
        end
        @(negedge clk);
    endtask

    // Compare against the model, apply this cycle's events, advance.
    task automatic cyc_end();
        bit      pop;
        bit      exp_req;
        int      occ;
        int      due;
        flight_t f;
        pop     = !stall_IM_ID && (queue_m.size() > 0);
        occ     = flight_q.size() + queue_m.size() - (pop ? 1 : 0);
        exp_req = !halted_m && !flow_change_ID_EX && (occ < QDEPTH);
        check("im_req", 32'(im_req), 32'(exp_req));
        check("occ_le_qdepth", 32'(flight_q.size() + queue_m.size() <= QDEPTH), 32'd1);
        if (im_req) check("im_addr", 32'(im_addr), 32'(issue_addr_m));
        check("instr_vld", 32'(instr_vld), 32'(queue_m.size() > 0));
        if (queue_m.size() > 0) begin
            check("instr", 32'(instr), 32'(im_word(queue_m[0])));
            check("nxt_pc", 32'(nxt_pc), 32'(16'(queue_m[0] + 16'd1)));
            last_nxt_m = 16'(queue_m[0] + 16'd1);
        end else begin
            check("bubble_instr", 32'(instr), 32'd0);
            check("held_nxt_pc", 32'(nxt_pc), 32'(last_nxt_m));
        end

        if (pop && !flow_change_ID_EX) begin
            $display("[cyc %0d] delivered addr=%h instr=%h nxt_pc=%h", cyc, queue_m[0], instr, nxt_pc);
            void'(queue_m.pop_front());
        end
        if (im_rvalid) begin
            f = flight_q.pop_front();
            if (!f.stale && !flow_change_ID_EX) queue_m.push_back(f.addr);
        end
        if (im_req && im_gnt) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (flight_q.size() > 0 && due <= flight_q[flight_q.size()-1].due)
                due = flight_q[flight_q.size()-1].due + 1;
            flight_q.push_back('{issue_addr_m, 1'b0, due});
            issue_addr_m = 16'(issue_addr_m + 16'd1);
        end
        if (flow_change_ID_EX) begin
            issue_addr_m = dst_ID_EX;
            foreach (flight_q[i]) flight_q[i].stale = 1'b1;
            queue_m.delete();
        end
        if (hlt_ID_EX) halted_m = 1'b1;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
            cyc_end();
        end
    endtask

    // Run until the first valid instruction and check it is address a.
    task automatic wait_first_vld(input string tag, input logic [15:0] a);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
            if (instr_vld) begin
                check({tag, "_instr"}, 32'(instr), 32'(im_word(a)));
                check({tag, "_nxt_pc"}, 32'(nxt_pc), 32'(16'(a + 16'd1)));
                found = 1'b1;
            end
            cyc_end();
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Assert reset in the middle of a cycle and check outputs clear at once.
    task automatic mid_cycle_reset(input string tag);
        cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_instr"}, 32'(instr), 32'd0);
        check({tag, "_vld"}, 32'(instr_vld), 32'd0);
        check({tag, "_req"}, 32'(im_req), 32'd0);
        check({tag, "_nxt_pc"}, 32'(nxt_pc), 32'd0);
        check({tag, "_addr"}, 32'(im_addr), 32'd0);
        model_reset();
        im_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit          seen, done;
        logic [15:0] held;
        n_cmp = 0; n_fail = 0; cyc = 0;
        lat_lo = 1; lat_hi = 1; gnt_pct = 100;
        rst_n = 1'b0; stall_IM_ID = 1'b0; flow_change_ID_EX = 1'b0;
        dst_ID_EX = 16'h0; hlt_ID_EX = 1'b0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 17'h0;
        model_reset();

        // Zero-wait memory, no stalls: request every cycle, valid from cycle 2.
        for (int i = 0; i < 8; i++) begin
            vecs[i].stall     = 1'b0;
            vecs[i].gnt       = 1'b1;
            vecs[i].exp_req   = 1'b1;
            vecs[i].exp_addr  = 16'(i);
            vecs[i].exp_vld   = (i >= 2);
            vecs[i].exp_instr = (i >= 2) ? im_word(16'(i - 2)) : 17'h0;
            vecs[i].exp_nxt   = (i >= 2) ? 16'(i - 1) : 16'h0;
        end

        #12;
        check("reset_im_req", 32'(im_req), 32'd0);
        check("reset_im_addr", 32'(im_addr), 32'h0000);
        check("reset_instr", 32'(instr), 32'd0);
        check("reset_vld", 32'(instr_vld), 32'd0);
        check("reset_nxt_pc", 32'(nxt_pc), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            gnt_pct = vecs[i].gnt ? 100 : 0;
            cyc_begin(vecs[i].stall, 1'b0, 16'h0, 1'b0);
            check("t1_req", 32'(im_req), 32'(vecs[i].exp_req));
            check("t1_addr", 32'(im_addr), 32'(vecs[i].exp_addr));
            check("t1_vld", 32'(instr_vld), 32'(vecs[i].exp_vld));
            check("t1_instr", 32'(instr), 32'(vecs[i].exp_instr));
            check("t1_nxt_pc", 32'(nxt_pc), 32'(vecs[i].exp_nxt));
            cyc_end();
        end
        gnt_pct = 100;

        // Stall until the queue is full, then hold for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1, 1'b0, 16'h0, 1'b0);
            cyc_end();
        end
        held = 16'h0006;
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1, 1'b0, 16'h0, 1'b0);
            check("stall_req_off", 32'(im_req), 32'd0);
            check("stall_vld", 32'(instr_vld), 32'd1);
            check("stall_instr_frozen", 32'(instr), 32'(im_word(held)));
            check("stall_nxt_frozen", 32'(nxt_pc), 32'(16'(held + 16'd1)));
            cyc_end();
        end
        idle(6);

        // Redirect with two fetches in flight.
        lat_lo = 3; lat_hi = 3;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            idle(1);
            done = (flight_q.size() == 2);
        end
        check("t3_two_in_flight", 32'(done), 32'd1);
        cyc_begin(1'b0, 1'b1, 16'h0040, 1'b0);
        check("redirect_req_off", 32'(im_req), 32'd0);
        cyc_end();
        wait_first_vld("redirect", 16'h0040);
        idle(6);

        // PC wrap at 16'hFFFF.
        lat_lo = 1; lat_hi = 1;
        cyc_begin(1'b0, 1'b1, 16'hFFFF, 1'b0);
        cyc_end();
        seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
            if (im_req && im_gnt) begin
                if (!seen) begin
                    check("wrap_addr_first", 32'(im_addr), 32'h0000FFFF);
                    seen = 1'b1;
                end else begin
                    check("wrap_addr_next", 32'(im_addr), 32'h00000000);
                    done = 1'b1;
                end
            end
            cyc_end();
        end
        check("wrap_issue_seen", 32'(done), 32'd1);
        wait_first_vld("wrap", 16'hFFFF);

        // Randomized traffic, fixed latency 4 then variable latency.
        lat_lo = 4; lat_hi = 4; gnt_pct = 50;
        for (int i = 0; i < 200; i++) begin
            cyc_begin(int'($urandom_range(99)) < 25, int'($urandom_range(99)) < 3,
                      16'($urandom), 1'b0);
            cyc_end();
        end
        lat_lo = 1; lat_hi = 6; gnt_pct = 70;
        for (int i = 0; i < 300; i++) begin
            cyc_begin(int'($urandom_range(99)) < 30, int'($urandom_range(99)) < 4,
                      16'($urandom), 1'b0);
            cyc_end();
        end

        // Asynchronous reset in the middle of fetching.
        lat_lo = 2; lat_hi = 2; gnt_pct = 100;
        idle(4);
        mid_cycle_reset("midrst");
        idle(10);

        // Halt: no more requests, queue still drains.
        cyc_begin(1'b0, 1'b0, 16'h0, 1'b1);
        cyc_end();
        for (int i = 0; i < 10; i++) begin
            cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
            check("halt_req_off", 32'(im_req), 32'd0);
            cyc_end();
        end
        mid_cycle_reset("haltrst");
        cyc_begin(1'b0, 1'b0, 16'h0, 1'b0);
        check("post_halt_reset_req", 32'(im_req), 32'd1);
        check("post_halt_reset_addr", 32'(im_addr), 32'h0000);
        cyc_end();
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
